// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input synchroniser plus an oversampled FSM that samples
// each bit at mid-bit and reports the word, parity status and framing errors.
module uart_rx_core #(
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned OVERSAMPLING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 rx_in,
  input  logic                 parEnable,
  input  logic                 parityType,
  output logic [DATAWIDTH-1:0] dataOutput,
  output logic                 dataValid,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int unsigned CW = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam int unsigned BW = $clog2(DATAWIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bitidx_q;
  logic [DATAWIDTH-1:0]   shreg_q;
  logic [1:0]             sync_q;
  logic                   armed_q;
  logic                   par_en_q;
  logic                   par_type_q;
  logic                   perr_q;
  logic [DATAWIDTH-1:0]   data_q;
  logic                   valid_q;
  logic                   perr_out_q;
  logic                   ferr_q;

  logic rxs;
  logic mid_hit;
  logic end_hit;

  assign rxs     = sync_q[1];
  assign mid_hit = (cnt_q == CW'(OVERSAMPLING / 2 - 1));
  assign end_hit = (cnt_q == CW'(OVERSAMPLING - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitidx_q   <= '0;
      shreg_q    <= '0;
      sync_q     <= '1;
      armed_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (bclk) begin
        cnt_q <= cnt_q + 1'b1;
        unique case (state_q)
          IDLE: begin
            // Requiring a high tick before a start edge keeps a stuck-low line
            // from retriggering after a framing error.
            if (rxs) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              par_en_q   <= parEnable;
              par_type_q <= parityType;
              perr_q     <= 1'b0;
              cnt_q      <= '0;
              state_q    <= START;
            end
          end
          START: begin
            if (mid_hit) begin
              cnt_q <= '0;
              if (rxs) begin
                state_q <= IDLE;
              end else begin
                bitidx_q <= '0;
                state_q  <= DATA;
              end
            end
          end
          DATA: begin
            if (end_hit) begin
              cnt_q    <= '0;
              shreg_q  <= {rxs, shreg_q[DATAWIDTH-1:1]};
              bitidx_q <= bitidx_q + 1'b1;
              if (bitidx_q == BW'(DATAWIDTH - 1)) begin
                state_q <= par_en_q ? PARITY : STOP;
              end
            end
          end
          PARITY: begin
            if (end_hit) begin
              cnt_q   <= '0;
              perr_q  <= ((^shreg_q) ^ rxs) != par_type_q;
              state_q <= STOP;
            end
          end
          STOP: begin
            if (end_hit) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              if (rxs) begin
                data_q     <= shreg_q;
                valid_q    <= 1'b1;
                perr_out_q <= perr_q;
                armed_q    <= 1'b1;
              end else begin
                ferr_q  <= 1'b1;
                armed_q <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dataOutput = data_q;
  assign dataValid  = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: bit-accurate serial frames at OVERSAMPLING=4
// with bclk every 2 clk (8 clk per bit).
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bclk = 1'b0;
  logic       rx_in = 1'b1;
  logic       parEnable = 1'b0;
  logic       parityType = 1'b0;
  logic [7:0] dataOutput;
  logic       dataValid;
  logic       parity_err;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_words[$];
  logic       rx_perr[$];
  int         fe_count = 0;

  uart_rx_core #(.DATAWIDTH(8), .OVERSAMPLING(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .rx_in     (rx_in),
    .parEnable (parEnable),
    .parityType(parityType),
    .dataOutput(dataOutput),
    .dataValid (dataValid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 bclk = ~bclk;
  end

  // Every cycle a pulse is high is recorded, so a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (dataValid) begin
        rx_words.push_back(dataOutput);
        rx_perr.push_back(parity_err);
      end
      if (frame_err) fe_count++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    wait_clks(8);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    wait_clks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clks(3);
    n_checks++;
    if (dataOutput !== 8'h00) begin
      n_errors++; $display("FAIL reset_dataOutput: got %h want 00", dataOutput);
    end
    n_checks++;
    if (dataValid !== 1'b0) begin
      n_errors++; $display("FAIL reset_dataValid: got %b want 0", dataValid);
    end
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err);
    end
    rst = 1'b0;
    idle(16);
  endtask

  task automatic test_basic;
    int base;
    int fb;
    base = rx_words.size();
    fb   = fe_count;
    parEnable = 1'b0;
    send_frame(8'hCC, 1'b0, 1'b0, 1'b1);
    idle(16);
    n_checks++;
    if (rx_words.size() !== base + 1) begin
      n_errors++; $display("FAIL basic_count: got %0d want %0d", rx_words.size(), base + 1);
    end else begin
      n_checks++;
      if (rx_words[base] !== 8'hCC) begin
        n_errors++; $display("FAIL basic_word: got %h want cc", rx_words[base]);
      end
      n_checks++;
      if (rx_perr[base] !== 1'b0) begin
        n_errors++; $display("FAIL basic_perr: got %b want 0", rx_perr[base]);
      end
    end
    n_checks++;
    if (fe_count !== fb) begin
      n_errors++; $display("FAIL basic_ferr: got %0d want %0d", fe_count, fb);
    end
  endtask

  task automatic test_parity;
    int base;
    logic [7:0] exp_w[3];
    logic       exp_p[3];
    base = rx_words.size();
    exp_w = '{8'h81, 8'h81, 8'h81};
    exp_p = '{1'b0, 1'b1, 1'b0};
    parEnable  = 1'b1;
    parityType = 1'b0;
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    idle(16);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    idle(16);
    n_checks++;
    if (parity_err !== 1'b1) begin
      n_errors++; $display("FAIL parity_hold: got %b want 1", parity_err);
    end
    parityType = 1'b1;
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    idle(16);
    n_checks++;
    if (rx_words.size() !== base + 3) begin
      n_errors++; $display("FAIL parity_count: got %0d want %0d", rx_words.size(), base + 3);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx_words[base+i] !== exp_w[i] || rx_perr[base+i] !== exp_p[i]) begin
          n_errors++;
          $display("FAIL parity_frame%0d: got %h/%b want %h/%b", i, rx_words[base+i],
                   rx_perr[base+i], exp_w[i], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int base;
    int fb;
    base = rx_words.size();
    fb   = fe_count;
    parEnable  = 1'b1;
    parityType = 1'b0;
    send_frame(8'hB9, 1'b1, 1'b1, 1'b1);
    send_frame(8'hEF, 1'b1, 1'b1, 1'b1);
    idle(16);
    n_checks++;
    if (rx_words.size() !== base + 2) begin
      n_errors++; $display("FAIL b2b_count: got %0d want %0d", rx_words.size(), base + 2);
    end else begin
      n_checks++;
      if (rx_words[base] !== 8'hB9 || rx_perr[base] !== 1'b0) begin
        n_errors++; $display("FAIL b2b_first: got %h/%b want b9/0", rx_words[base], rx_perr[base]);
      end
      n_checks++;
      if (rx_words[base+1] !== 8'hEF || rx_perr[base+1] !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_second: got %h/%b want ef/0", rx_words[base+1], rx_perr[base+1]);
      end
    end
    n_checks++;
    if (fe_count !== fb) begin
      n_errors++; $display("FAIL b2b_ferr: got %0d want %0d", fe_count, fb);
    end
  endtask

  task automatic test_cfg_frozen;
    int base;
    int fb;
    base = rx_words.size();
    fb   = fe_count;
    parEnable  = 1'b1;
    parityType = 1'b0;
    fork
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      begin
        wait_clks(30);
        parEnable  = 1'b0;
        parityType = 1'b1;
      end
    join
    idle(16);
    n_checks++;
    if (rx_words.size() !== base + 1 || fe_count !== fb) begin
      n_errors++;
      $display("FAIL cfg_frozen_count: got %0d words %0d ferr want 1 and 0",
               rx_words.size() - base, fe_count - fb);
    end else begin
      n_checks++;
      if (rx_words[base] !== 8'h3C || rx_perr[base] !== 1'b0) begin
        n_errors++;
        $display("FAIL cfg_frozen_word: got %h/%b want 3c/0", rx_words[base], rx_perr[base]);
      end
    end
  endtask

  task automatic test_glitch;
    int base;
    int fb;
    base = rx_words.size();
    fb   = fe_count;
    parEnable = 1'b0;
    rx_in = 1'b0;
    wait_clks(2);
    idle(40);
    n_checks++;
    if (rx_words.size() !== base || fe_count !== fb) begin
      n_errors++;
      $display("FAIL glitch_reject: got %0d words %0d ferr want 0 and 0",
               rx_words.size() - base, fe_count - fb);
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle(16);
    n_checks++;
    if (rx_words.size() !== base + 1) begin
      n_errors++; $display("FAIL glitch_recover_count: got %0d want 1", rx_words.size() - base);
    end else if (rx_words[base] !== 8'h5A) begin
      n_errors++; $display("FAIL glitch_recover_word: got %h want 5a", rx_words[base]);
    end
  endtask

  task automatic test_break;
    int base;
    int fb;
    base = rx_words.size();
    fb   = fe_count;
    parEnable = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b0;
    wait_clks(40);
    n_checks++;
    if (fe_count !== fb + 1) begin
      n_errors++; $display("FAIL break_ferr: got %0d pulses want 1", fe_count - fb);
    end
    n_checks++;
    if (rx_words.size() !== base) begin
      n_errors++; $display("FAIL break_valid: got %0d words want 0", rx_words.size() - base);
    end
    n_checks++;
    if (dataOutput !== 8'h5A) begin
      n_errors++; $display("FAIL break_hold: got %h want 5a", dataOutput);
    end
    idle(16);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    idle(16);
    n_checks++;
    if (rx_words.size() !== base + 1 || fe_count !== fb + 1) begin
      n_errors++;
      $display("FAIL break_recover_count: got %0d words %0d ferr want 1 and 1",
               rx_words.size() - base, fe_count - fb);
    end else if (rx_words[base] !== 8'h3C) begin
      n_errors++; $display("FAIL break_recover_word: got %h want 3c", rx_words[base]);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    int fb;
    base = rx_words.size();
    fb   = fe_count;
    parEnable = 1'b0;
    // Aborted word F8: bits 3..7 and stop are high, so the line stays idle after reset.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rx_in = 1'b1;
    wait_clks(4);
    rst = 1'b1;
    wait_clks(1);
    n_checks++;
    if (dataOutput !== 8'h00 || dataValid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got %h/%b/%b/%b want 00/0/0/0", dataOutput, dataValid,
               parity_err, frame_err);
    end
    rst = 1'b0;
    idle(3 + 40 + 16);
    n_checks++;
    if (rx_words.size() !== base || fe_count !== fb) begin
      n_errors++;
      $display("FAIL midreset_abort: got %0d words %0d ferr want 0 and 0",
               rx_words.size() - base, fe_count - fb);
    end
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(16);
    n_checks++;
    if (rx_words.size() !== base + 1) begin
      n_errors++; $display("FAIL midreset_next_count: got %0d want 1", rx_words.size() - base);
    end else if (rx_words[base] !== 8'hA5 || rx_perr[base] !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_next_word: got %h/%b want a5/0", rx_words[base], rx_perr[base]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_back_to_back;
    test_cfg_frozen;
    test_glitch;
    test_break;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive stage of the UART; consumes the line driven by the TXTOP transmitter (tx_out) and rebuilds parallel words.
- Shares the oversampling tick (bclk) from BAUD_RATE_GENERATOR with the transmitter.
- Frame format matches TX: start, DATAWIDTH data bits LSB first, optional parity, one stop bit.
- Outputs a one-cycle dataValid pulse with the word, plus per-frame parity and framing error flags.

Parameters:
- DATAWIDTH, 8, data bits per frame
- OVERSAMPLING, 4, bclk ticks per bit; even, >=4

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- bclk  input  1  oversample tick; one-clk-wide enable pulse at OVERSAMPLING x baud
- rx_in  input  1  serial line; idle high; asynchronous to clk
- parEnable  input  1  1 = parity bit present
- parityType  input  1  0 = even, 1 = odd
- dataOutput  output  DATAWIDTH  last received word
- dataValid  output  1  one-clk pulse, new word on dataOutput
- parity_err  output  1  parity status of the word flagged by dataValid
- frame_err  output  1  one-clk pulse, stop bit sampled 0

Behaviour:
Reset (synchronous, active-high; may hit mid-frame):
- Synchronous, active-high; also applies mid-frame.
- Every register returns to its reset value on the first clk edge with rst=1: state=IDLE, counters=0, shift register=0, armed=0, synchroniser flops=1.
- Outputs: dataOutput=0, dataValid=0, parity_err=0, frame_err=0.
- No partial word is ever emitted.

Input synchroniser:
- rx_in passes through a 2-flop synchroniser; call the result rxs.
- All decisions use rxs and change only on clk edges where bclk=1.

Tick counter:
- cnt, width clog2(OVERSAMPLING); set to 0 on every state entry.
- Increments on each bclk tick.

States:
- IDLE:
  - On a tick with rxs=1: set armed=1.
  - On a tick with rxs=0 and armed=1: latch parEnable and parityType, go to START, cnt=0.
  - These settings are frozen for the whole frame.
- START:
  - On the tick where cnt==OVERSAMPLING/2-1, sample rxs (mid start bit).
  - rxs=1: false start; go to IDLE, no outputs, armed stays 1.
  - rxs=0: go to DATA, cnt=0, bitidx=0.
- DATA:
  - On the tick where cnt==OVERSAMPLING-1, sample rxs and shift it in LSB first (shreg <= {rxs, shreg[DATAWIDTH-1:1]}), then cnt=0.
  - After DATAWIDTH samples: go to PARITY if the latched parEnable=1, otherwise STOP.
- PARITY:
  - Sample at cnt==OVERSAMPLING-1.
  - perr = (^shreg ^ rxs) != latched parityType.
  - Even parity: total count of ones, parity bit included, must be even.
- STOP:
  - Sample at cnt==OVERSAMPLING-1, then go to IDLE.
  - rxs=1: load dataOutput<=shreg; pulse dataValid; parity_err<=perr (0 if no parity); armed=1.
  - rxs=0: pulse frame_err; no dataValid; dataOutput unchanged; armed=0. A break or stuck-low line never retriggers a frame.

Output timing:
- dataValid and frame_err are registered. Each is high for exactly the one clk cycle after the stop-sample edge.
- parity_err and dataOutput hold their values until the next dataValid.
- Sample points: start + OVERSAMPLING/2 ticks, then every OVERSAMPLING ticks, so each bit is sampled at mid-bit.
- Back-to-back frames: a start edge on the tick immediately after the stop sample is accepted.
- Changes to parEnable or parityType mid-frame are ignored.
- bclk never asserted: the FSM is frozen.

Test Plan:
(OVERSAMPLING=4; DIV=2 so bclk fires every 2 clk; TX frames driven bit-accurately.)
- Frame 8'b11001100, parity disabled -> one dataValid pulse, dataOutput=8'hCC, parity_err=0, frame_err=0. Pulse arrives 1 clk after the stop mid-sample.
- Frame 8'b10000001, even parity, parity bit 0 -> dataOutput=8'h81, parity_err=0. Repeat with parity bit forced to 1 -> dataValid with parity_err=1.
- TXTOP loopback (tx_out to rx_in, shared bclk), words 8'hB9 and 8'hEF with parEnable=1, parityType=0, sent back to back -> two dataValid pulses in order, values B9 then EF, no errors.
- rx_in low for 1 tick only (glitch) -> START rejects it at the mid sample; no dataValid, no frame_err, FSM back in IDLE.
- Frame 8'h55 with stop bit 0, line then held low for 20 ticks -> single frame_err pulse, no dataValid, dataOutput unchanged. No new frame until rx_in returns high, then a 8'h3C frame is received correctly.
- Reset asserted for 1 clk during DATA bit 3 of a frame -> all outputs 0 next cycle, no dataValid for the aborted frame. The next complete frame (8'hA5) is received correctly.
